// File: rtl/scc_output_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scc_output_stage: DC removal, IIR low-pass, gain/saturation to 16-bit PCM, |
// | plus a first-order 1-bit delta-sigma DAC.            Revision: 1.0         |
// +----------------------------------------------------------------------------+
module scc_output_stage #(
  parameter int FILTER_SHIFT = 2,
  parameter int DC_OFFSET    = 640
) (
  input  logic               nreset,
  input  logic               clk,
  input  logic               enable,
  input  logic [2:0]         active,
  input  logic [10:0]        mix_in,
  input  logic               mute,
  input  logic [1:0]         gain,
  output logic signed [15:0] sound_out,
  output logic               sample_valid,
  output logic               dac_out
);

  localparam int ACC_W = 12 + FILTER_SHIFT + 2;
  localparam int P_W   = ACC_W + 6;

  logic signed [11:0]      x_q, x_d;
  logic                    v1_q, v1_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    v2_q, v2_d;
  logic signed [15:0]      sound_q, sound_d;
  logic                    valid_q, valid_d;
  logic [15:0]             ds_q, ds_d;
  logic                    dac_q, dac_d;

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] y;
  logic signed [P_W-1:0]   y_ext;
  logic signed [P_W-1:0]   p;
  logic signed [15:0]      p_sat;
  logic [16:0]             ds_sum;

  // Filter output kept in its own signed assignment so the shift stays arithmetic.
  assign y      = acc_q >>> FILTER_SHIFT;
  assign x_ext  = {{(ACC_W-12){x_q[11]}}, x_q};
  assign y_ext  = {{(P_W-ACC_W){y[ACC_W-1]}}, y};
  assign p      = y_ext <<< (3 + gain);
  assign ds_sum = {1'b0, ds_q} + {1'b0, sound_q ^ 16'h8000};

  always_comb begin
    if (p > 32767)       p_sat = 16'sh7FFF;
    else if (p < -32768) p_sat = -16'sh8000;
    else                 p_sat = p[15:0];
  end

  always_comb begin
    x_d     = x_q;
    v1_d    = v1_q;
    acc_d   = acc_q;
    v2_d    = v2_q;
    sound_d = sound_q;
    ds_d    = ds_q;
    dac_d   = dac_q;
    valid_d = 1'b0;
    if (enable) begin
      v1_d = (active == 3'd2);
      if (active == 3'd2)
        x_d = {1'b0, mix_in} - 12'(DC_OFFSET);
      v2_d = v1_q;
      if (v1_q)
        acc_d = acc_q + x_ext - y;
      if (v2_q) begin
        sound_d = mute ? 16'sd0 : p_sat;
        valid_d = 1'b1;
      end
      ds_d  = ds_sum[15:0];
      dac_d = ds_sum[16];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_q     <= '0;
      v1_q    <= 1'b0;
      acc_q   <= '0;
      v2_q    <= 1'b0;
      sound_q <= '0;
      valid_q <= 1'b0;
      ds_q    <= '0;
      dac_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      v1_q    <= v1_d;
      acc_q   <= acc_d;
      v2_q    <= v2_d;
      sound_q <= sound_d;
      valid_q <= valid_d;
      ds_q    <= ds_d;
      dac_q   <= dac_d;
    end
  end

  assign sound_out    = sound_q;
  assign sample_valid = valid_q;
  assign dac_out      = dac_q;

endmodule
`default_nettype wire

// File: tb/tb_scc_output_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scc_output_stage: directed vectors for the SCC output stage, using one  |
// | filtered (FILTER_SHIFT=2) and one bypass (FILTER_SHIFT=0) instance.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_scc_output_stage;

  logic              clk    = 1'b0;
  logic              nreset = 1'b0;
  logic              enable = 1'b0;
  logic              mute   = 1'b0;
  logic [2:0]        active = 3'd0;
  logic [10:0]       mix_in = 11'd0;
  logic [1:0]        gain   = 2'd0;
  logic signed [15:0] so2, so0;
  logic              sv2, sv0, dac2, dac0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int mix;
    int g;
    bit m;
    int exp;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  scc_output_stage #(.FILTER_SHIFT(2), .DC_OFFSET(640)) dut (
    .nreset(nreset), .clk(clk), .enable(enable), .active(active),
    .mix_in(mix_in), .mute(mute), .gain(gain),
    .sound_out(so2), .sample_valid(sv2), .dac_out(dac2)
  );

  scc_output_stage #(.FILTER_SHIFT(0), .DC_OFFSET(640)) dut0 (
    .nreset(nreset), .clk(clk), .enable(enable), .active(active),
    .mix_in(mix_in), .mute(mute), .gain(gain),
    .sound_out(so0), .sample_valid(sv0), .dac_out(dac0)
  );

  // The bench plays the role of the mixer slot counter.
  task automatic tick();
    @(posedge clk);
    #1;
    if (enable) active = (active == 3'd5) ? 3'd0 : active + 3'd1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit use0, input string name, output int n);
    int found;
    found = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if ((use0 ? sv0 : sv2) === 1'b1) begin
        found = 1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int v;
    int ok;
    int ones;
    int d_prev;

    tbl[0] = '{1275, 3, 1'b0, 32767};
    tbl[1] = '{0,    3, 1'b0, -32768};
    tbl[2] = '{1140, 3, 1'b0, 32000};
    tbl[3] = '{1275, 0, 1'b1, 0};
    tbl[4] = '{1275, 0, 1'b0, 5080};
    tbl[5] = '{640,  2, 1'b0, 0};
    tbl[6] = '{0,    0, 1'b0, -5120};
    tbl[7] = '{700,  1, 1'b0, 960};
    tbl[8] = '{1000, 2, 1'b0, 11520};
    tbl[9] = '{600,  3, 1'b0, -2560};

    // Reset state
    repeat (3) tick();
    check("rst_sound2", so2, 0);
    check("rst_valid2", sv2, 0);
    check("rst_dac2", dac2, 0);
    check("rst_sound0", so0, 0);
    check("rst_valid0", sv0, 0);
    check("rst_dac0", dac0, 0);

    // DC removal and IIR settling
    nreset = 1'b1;
    enable = 1'b1;
    gain   = 2'd0;
    mute   = 1'b0;
    mix_in = 11'd1140;
    wait_valid(1'b0, "settle_first_valid", n);
    check("settle_first", so2, 1000);
    wait_valid(1'b0, "settle_second_valid", n);
    check("valid_period", n, 6);
    check("settle_second", so2, 1744);
    for (int i = 0; i < 40; i++) wait_valid(1'b0, "settle_run_valid", n);
    check("settle_final", so2, 4000);

    // Muted output while the filter keeps tracking a new level
    mute   = 1'b1;
    mix_in = 11'd1275;
    for (int i = 0; i < 30; i++) wait_valid(1'b0, "mute_run_valid", n);
    check("mute_zero", so2, 0);
    mute = 1'b0;
    wait_valid(1'b0, "mute_release_valid", n);
    check("mute_release_tracked", so2, 5080);

    // Gain / saturation / mute vectors on the bypass instance
    for (int i = 0; i < 10; i++) begin
      mix_in = 11'(tbl[i].mix);
      gain   = 2'(tbl[i].g);
      mute   = tbl[i].m;
      repeat (13) tick();
      check($sformatf("vec%0d", i), so0, tbl[i].exp);
    end

    // Enable low: everything holds, sample_valid drops after one clock
    wait_valid(1'b1, "freeze_pre_valid", n);
    d_prev = int'(dac0);
    enable = 1'b0;
    v = int'(active);
    tick();
    check("freeze_valid_clears", sv0, 0);
    active = 3'd2;
    mix_in = 11'd0;
    ok = 1;
    repeat (19) begin
      tick();
      if (so0 !== 16'(tbl[9].exp) || int'(dac0) != d_prev || sv0 !== 1'b0) ok = 0;
    end
    check("freeze_hold", ok, 1);
    check("freeze_sound", so0, tbl[9].exp);
    active = 3'(v);
    mix_in = 11'(tbl[9].mix);
    enable = 1'b1;

    // Capture gating: mix_in only matters when active==2
    gain   = 2'd0;
    mute   = 1'b0;
    mix_in = 11'd1275;
    repeat (13) tick();
    check("gate_base", so0, 5080);
    ok = 1;
    repeat (12) begin
      mix_in = (active == 3'd2) ? 11'd1275 : 11'($urandom_range(0, 1275));
      tick();
      if (so0 !== 16'sd5080) ok = 0;
    end
    check("gate_hold", ok, 1);

    // Latency from the capture edge
    n = 0;
    while (active != 3'd2 && n < 6) begin
      mix_in = 11'($urandom_range(0, 1275));
      tick();
      n++;
    end
    mix_in = 11'd700;
    tick();
    mix_in = 11'($urandom_range(0, 1275));
    check("lat_capture_edge", so0, 5080);
    check("lat_capture_valid", sv0, 0);
    tick();
    check("lat_s2_edge", so0, 5080);
    tick();
    check("lat_s3_edge", so0, 480);
    check("lat_s3_valid", sv0, 1);

    // Delta-sigma: mid-scale toggles
    mix_in = 11'd640;
    gain   = 2'd0;
    repeat (13) tick();
    check("ds_mid_sound", so0, 0);
    d_prev = int'(dac0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ds_toggle%0d", i), int'(dac0), (d_prev != 0) ? 0 : 1);
      d_prev = int'(dac0);
    end

    // Delta-sigma: full-scale positive is almost always 1
    mix_in = 11'd1275;
    gain   = 2'd3;
    repeat (13) tick();
    check("ds_max_sound", so0, 32767);
    ones = 0;
    repeat (100) begin
      tick();
      ones += int'(dac0);
    end
    check("ds_max_ones", (ones >= 99) ? 1 : 0, 1);

    // Delta-sigma: full-scale negative is constant 0
    mix_in = 11'd0;
    repeat (13) tick();
    check("ds_min_sound", so0, -32768);
    ones = 0;
    repeat (20) begin
      tick();
      ones += int'(dac0);
    end
    check("ds_min_ones", ones, 0);

    // Asynchronous reset right after a capture discards the in-flight sample
    n = 0;
    while (active != 3'd2 && n < 6) begin
      tick();
      n++;
    end
    mix_in = 11'd1275;
    tick();
    #2 nreset = 1'b0;
    #1;
    check("arst_sound0", so0, 0);
    check("arst_valid0", sv0, 0);
    check("arst_dac0", dac0, 0);
    check("arst_sound2", so2, 0);
    tick();
    nreset = 1'b1;
    ok = 1;
    repeat (2) begin
      tick();
      if (sv0 !== 1'b0) ok = 0;
    end
    check("arst_discard", ok, 1);
    wait_valid(1'b1, "arst_next_valid", n);
    check("arst_next_sample", so0, 32767);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
